mdll_fcal_search: RTL and testbench
===================================

Name: mdll_fcal_search

Overview:
- Sequencer for MDLL coarse frequency calibration.
- On a JTAG-issued start, runs an MSB-first successive-approximation search over the DCO control offset. Each trial loads a candidate offset, waits a settle time, runs one frequency-count measurement through the MDLL fcal handshake and compares the count with a target.
- Sits between the JTAG register bank and the MDLL debug interface. It drives the offset/load/fcal_start controls and returns the result and status to JTAG read registers.

Parameters:
- N_OFFSET, 5: width of dco_ctl_offset; number of SAR trials.
- N_CNT, 10: width of fcal_cnt and target_cnt.
- TIMEOUT, 1023: maximum cycles spent in MEAS or RELEASE before aborting.

Ports:
- clk  input  1  block clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  JTAG level; a rising edge requests a calibration.
- target_cnt  input  N_CNT  desired fcal count.
- settle_cycles  input  8  wait after each offset load; 0 means no wait.
- fcal_ready  input  1  MDLL: measurement complete, fcal_cnt valid.
- fcal_cnt  input  N_CNT  MDLL measured count.
- dco_ctl_offset  output  N_OFFSET  offset applied to the DCO.
- load_offset  output  1  one-cycle pulse that loads dco_ctl_offset into the MDLL.
- fcal_start  output  1  held high to request and hold a measurement.
- busy  output  1  search in progress.
- done  output  1  sticky completion flag.
- timeout_err  output  1  sticky abort flag.
- best_offset  output  N_OFFSET  trial offset with the smallest |cnt-target|.
- best_cnt  output  N_CNT  count measured at best_offset.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous, active-high, and dominates every state including mid-search.
  - The cycle after rst, all outputs are 0 and the FSM is in IDLE.
  - The start edge detector register is also cleared, so a start held high through reset does not trigger a run.
- States: IDLE, LOAD, SETTLE, MEAS, RELEASE, DECIDE, FINISH.
- IDLE
  - Accepts a run on a start rising edge only, i.e. start=1 with the registered previous start=0.
  - On accept: clear done and timeout_err, set busy, set bit index i=N_OFFSET-1, set the trial offset to 0 with bit i forced to 1, clear the best tracker, go to LOAD.
- LOAD (1 cycle): dco_ctl_offset=trial, load_offset=1. Go to SETTLE, or to MEAS if settle_cycles=0.
- SETTLE: count settle_cycles cycles, then go to MEAS.
- MEAS
  - fcal_start=1. Load a watchdog on entry.
  - fcal_ready=1: capture fcal_cnt, drop fcal_start next cycle, go to RELEASE.
  - Watchdog hits TIMEOUT cycles with no ready: abort.
- RELEASE
  - fcal_start=0. Wait for fcal_ready=0, then go to DECIDE.
  - Same TIMEOUT watchdog, reloaded on entry.
- DECIDE (1 cycle)
  - err=|cnt-target|, computed as unsigned N_CNT bits with no overflow (subtract the smaller from the larger).
  - If this is the first trial or err < best_err (strict; ties keep the earlier trial), update best_offset, best_cnt and best_err.
  - If cnt > target_cnt, clear bit i in trial (a higher offset means a higher frequency); otherwise keep it.
  - If i>0: i=i-1, set bit i, go to LOAD. If i=0, go to FINISH.
- FINISH (1 cycle)
  - dco_ctl_offset=final SAR value, load_offset=1.
  - busy=0, done=1, go to IDLE.
  - The final value may be one that was never measured, e.g. 0.
- Abort
  - Next cycle: fcal_start=0, busy=0, done=1, timeout_err=1.
  - dco_ctl_offset keeps the last loaded trial and no load pulse is issued.
  - best_* hold the results of completed trials; both are 0 if no trial completed.
- Start handling:
  - A start edge while busy is ignored.
  - done and timeout_err hold until the next accepted start or rst.
- Latency: each trial takes 1 + settle_cycles + (cycles to ready) + (cycles to ready low) + 1. FINISH adds 1 cycle.
- dco_ctl_offset changes only in LOAD, FINISH and rst.
- fcal_start is never high outside MEAS.

Test Plan:
- Settled search: model cnt=20*offset+100, target=400, settle=4, ready 8 cycles after fcal_start -> trials 16,8,12,14,15; final dco_ctl_offset=15, best_offset=15, best_cnt=400, done=1, timeout_err=0, exactly 6 load_offset pulses.
- Below range: same model, target=0 -> trials 16,8,4,2,1 all cleared; final offset 0, best_offset=1, best_cnt=120.
- Timeout: model never raises fcal_ready -> abort after 1023 MEAS cycles; fcal_start=0, busy=0, done=1, timeout_err=1, dco_ctl_offset=16.
- Reset and start filtering:
  - rst pulsed during the third trial's MEAS -> next cycle all outputs 0.
  - start held high across rst -> no run.
  - A later 0->1 edge on start -> fresh run.
- Start edge while busy -> ignored; result identical to the first scenario, and done is not cleared mid-run.
- Zero settle and tie: settle_cycles=0, model with an equal err at offsets 8 and 12 -> MEAS entered the cycle after LOAD; best_offset=8.

Source files
------------

// File: rtl/mdll_fcal_search.sv
// mdll_fcal_search
// Sequencer for MDLL coarse frequency calibration. A JTAG start edge launches
// an MSB-first successive-approximation search over the DCO control offset.
// Each trial loads a candidate offset, waits settle_cycles, runs one frequency
// count through the fcal handshake and compares the count against target_cnt.
// The trial with the smallest |cnt - target| is reported on best_*.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : JTAG level, rising edge requests a calibration
//   target_cnt      : desired fcal count
//   settle_cycles   : wait after each offset load (0 = no wait)
//   fcal_ready      : MDLL measurement complete, fcal_cnt valid
//   fcal_cnt        : MDLL measured count
//   dco_ctl_offset  : offset applied to the DCO
//   load_offset     : one-cycle pulse loading dco_ctl_offset into the MDLL
//   fcal_start      : held high to request/hold a measurement
//   busy            : search in progress
//   done            : sticky completion flag
//   timeout_err     : sticky abort flag
//   best_offset     : trial offset with the smallest |cnt - target|
//   best_cnt        : count measured at best_offset
module mdll_fcal_search #(
   parameter int N_OFFSET = 5,
   parameter int N_CNT    = 10,
   parameter int TIMEOUT  = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [N_CNT-1:0]    target_cnt,
   input  logic [7:0]          settle_cycles,
   input  logic                fcal_ready,
   input  logic [N_CNT-1:0]    fcal_cnt,
   output logic [N_OFFSET-1:0] dco_ctl_offset,
   output logic                load_offset,
   output logic                fcal_start,
   output logic                busy,
   output logic                done,
   output logic                timeout_err,
   output logic [N_OFFSET-1:0] best_offset,
   output logic [N_CNT-1:0]    best_cnt
);

   localparam int IW = (N_OFFSET > 1) ? $clog2(N_OFFSET) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_RELEASE, S_DECIDE, S_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic                arm_q, arm_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [N_OFFSET-1:0] trial_q, trial_d;
   logic [N_OFFSET-1:0] dco_q, dco_d;
   logic                load_q, load_d;
   logic                fstart_q, fstart_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                tout_q, tout_d;
   logic [N_OFFSET-1:0] boff_q, boff_d;
   logic [N_CNT-1:0]    bcnt_q, bcnt_d;
   logic [N_CNT-1:0]    berr_q, berr_d;
   logic                have_q, have_d;
   logic [N_CNT-1:0]    cnt_q, cnt_d;
   logic [7:0]          settle_q, settle_d;
   logic [WW-1:0]       wd_q, wd_d;

   logic [N_CNT-1:0]    err_s;
   logic [N_OFFSET-1:0] bit_s;
   logic [N_OFFSET-1:0] next_bit_s;
   logic [N_OFFSET-1:0] trial_dec_s;

   // State and output registers; rst clears everything including the start arm.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         arm_q    <= 1'b0;
         idx_q    <= '0;
         trial_q  <= '0;
         dco_q    <= '0;
         load_q   <= 1'b0;
         fstart_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         tout_q   <= 1'b0;
         boff_q   <= '0;
         bcnt_q   <= '0;
         berr_q   <= '0;
         have_q   <= 1'b0;
         cnt_q    <= '0;
         settle_q <= '0;
         wd_q     <= '0;
      end else begin
         state_q  <= state_d;
         arm_q    <= arm_d;
         idx_q    <= idx_d;
         trial_q  <= trial_d;
         dco_q    <= dco_d;
         load_q   <= load_d;
         fstart_q <= fstart_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         tout_q   <= tout_d;
         boff_q   <= boff_d;
         bcnt_q   <= bcnt_d;
         berr_q   <= berr_d;
         have_q   <= have_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         wd_q     <= wd_d;
      end
   end

   // Trial arithmetic: absolute error without overflow and the SAR bit update.
   always_comb begin
      if (cnt_q > target_cnt) begin
         err_s = cnt_q - target_cnt;
      end else begin
         err_s = target_cnt - cnt_q;
      end
      bit_s      = N_OFFSET'(1) << idx_q;
      next_bit_s = N_OFFSET'(1) << (idx_q - IW'(1));
      // Count too high means frequency too high: drop the bit under test.
      if (cnt_q > target_cnt) begin
         trial_dec_s = trial_q & ~bit_s;
      end else begin
         trial_dec_s = trial_q;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      trial_d  = trial_q;
      dco_d    = dco_q;
      load_d   = 1'b0;
      fstart_d = fstart_q;
      busy_d   = busy_q;
      done_d   = done_q;
      tout_d   = tout_q;
      boff_d   = boff_q;
      bcnt_d   = bcnt_q;
      berr_d   = berr_q;
      have_d   = have_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      wd_d     = wd_q;
      // Armed only after start has been seen low; reset disarms it so a start
      // held high through reset cannot launch a run.
      arm_d    = ~start;

      case (state_q)
         S_IDLE: begin
            if (start && arm_q) begin
               done_d  = 1'b0;
               tout_d  = 1'b0;
               busy_d  = 1'b1;
               idx_d   = IW'(N_OFFSET - 1);
               trial_d = N_OFFSET'(1) << (N_OFFSET - 1);
               dco_d   = N_OFFSET'(1) << (N_OFFSET - 1);
               load_d  = 1'b1;
               boff_d  = '0;
               bcnt_d  = '0;
               berr_d  = '0;
               have_d  = 1'b0;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            if (settle_cycles == 8'd0) begin
               fstart_d = 1'b1;
               wd_d     = '0;
               state_d  = S_MEAS;
            end else begin
               settle_d = 8'd0;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (({1'b0, settle_q} + 9'd1) >= {1'b0, settle_cycles}) begin
               fstart_d = 1'b1;
               wd_d     = '0;
               state_d  = S_MEAS;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         S_MEAS: begin
            if (fcal_ready) begin
               cnt_d    = fcal_cnt;
               fstart_d = 1'b0;
               wd_d     = '0;
               state_d  = S_RELEASE;
            end else if (wd_q >= WW'(TIMEOUT - 1)) begin
               fstart_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               tout_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         S_RELEASE: begin
            if (!fcal_ready) begin
               state_d = S_DECIDE;
            end else if (wd_q >= WW'(TIMEOUT - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               tout_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         S_DECIDE: begin
            // Strict compare: on a tie the earlier trial is kept.
            if (!have_q || (err_s < berr_q)) begin
               boff_d = trial_q;
               bcnt_d = cnt_q;
               berr_d = err_s;
               have_d = 1'b1;
            end else begin
               have_d = have_q;
            end
            if (idx_q != '0) begin
               idx_d   = idx_q - IW'(1);
               trial_d = trial_dec_s | next_bit_s;
               dco_d   = trial_dec_s | next_bit_s;
               load_d  = 1'b1;
               state_d = S_LOAD;
            end else begin
               // Final SAR value is applied even if it was never measured.
               trial_d = trial_dec_s;
               dco_d   = trial_dec_s;
               load_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            fstart_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign dco_ctl_offset = dco_q;
   assign load_offset    = load_q;
   assign fcal_start     = fstart_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign timeout_err    = tout_q;
   assign best_offset    = boff_q;
   assign best_cnt       = bcnt_q;

endmodule

// File: tb/tb_mdll_fcal_search.sv
// Testbench for mdll_fcal_search: an MDLL stand-in answers the fcal handshake
// from a per-offset count table; searches are checked against a direct SAR
// reference model, a fixed vector table and hand-written corner sequences.
module tb_mdll_fcal_search;
   localparam int NO = 5;
   localparam int NC = 10;
   localparam int TO = 1023;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [NC-1:0] target_cnt = '0;
   logic [7:0]    settle_cycles = 8'd0;
   logic          fcal_ready = 1'b0;
   logic [NC-1:0] fcal_cnt = '0;
   logic [NO-1:0] dco_ctl_offset;
   logic          load_offset;
   logic          fcal_start;
   logic          busy;
   logic          done;
   logic          timeout_err;
   logic [NO-1:0] best_offset;
   logic [NC-1:0] best_cnt;

   mdll_fcal_search #(.N_OFFSET(NO), .N_CNT(NC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .target_cnt(target_cnt),
      .settle_cycles(settle_cycles), .fcal_ready(fcal_ready), .fcal_cnt(fcal_cnt),
      .dco_ctl_offset(dco_ctl_offset), .load_offset(load_offset),
      .fcal_start(fcal_start), .busy(busy), .done(done), .timeout_err(timeout_err),
      .best_offset(best_offset), .best_cnt(best_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // MDLL stand-in: latches the offset on load, raises ready dly cycles into
   // a measurement with the table count, drops ready once fcal_start falls.
   int tab [32];
   int dly = 1;
   bit no_ready = 1'b0;
   int lat_off = 0;
   int mcnt = 0;
   always @(negedge clk) begin
      if (load_offset) lat_off = int'(dco_ctl_offset);
      if (fcal_start) begin
         mcnt++;
         if (!no_ready && mcnt >= dly) begin
            fcal_ready = 1'b1;
            fcal_cnt   = NC'(tab[lat_off]);
         end
      end else begin
         mcnt = 0;
         fcal_ready = 1'b0;
      end
   end

   // Monitor: logs load pulses and fcal_start rises, checks offset stability.
   int nloads = 0;
   int load_cyc [16];
   int load_val [16];
   int nfs_rise = 0;
   int fs_rise_cyc = 0;
   logic prev_fs = 1'b0;
   logic [NO-1:0] prev_dco = '0;
   logic rst_hit = 1'b1;
   always @(posedge clk) rst_hit <= rst;
   always @(negedge clk) begin
      if (load_offset) begin
         if (nloads < 16) begin
            load_cyc[nloads] = cyc;
            load_val[nloads] = int'(dco_ctl_offset);
         end
         nloads++;
      end
      if (fcal_start && !prev_fs) begin
         if (nfs_rise == 0) fs_rise_cyc = cyc;
         nfs_rise++;
      end
      if (!rst_hit && dco_ctl_offset != prev_dco) begin
         checks++;
         if (!load_offset) begin
            errors++;
            $display("FAIL dco_change_without_load: got load=%0d, expected 1 (dco %0d->%0d)",
                     load_offset, prev_dco, dco_ctl_offset);
         end
      end
      prev_fs  = fcal_start;
      prev_dco = dco_ctl_offset;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_linear(input int slope, input int base);
      for (int o = 0; o < 32; o++) tab[o] = (slope * o + base) & 1023;
   endtask

   // Reference: the SAR rules applied directly to the count table.
   task automatic ref_sar(input int tgt, output int fin, output int boff, output int bcnt);
      int trial, c, e, berr;
      bit first;
      trial = 0; first = 1'b1; boff = 0; bcnt = 0; berr = 0;
      for (int b = NO - 1; b >= 0; b--) begin
         trial = trial | (1 << b);
         c = tab[trial];
         e = (c > tgt) ? c - tgt : tgt - c;
         if (first || e < berr) begin
            boff = trial; bcnt = c; berr = e; first = 1'b0;
         end
         if (c > tgt) trial = trial & ~(1 << b);
      end
      fin = trial;
   endtask

   task automatic kick();
      nloads = 0;
      nfs_rise = 0;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
   endtask

   // Wait for completion; optionally re-pulse start mid-run at iteration glitch.
   task automatic wait_done(input string name, input int glitch);
      int done_bad;
      bit seen_busy;
      done_bad = 0;
      seen_busy = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
         if (busy && done) done_bad++;
         if (glitch > 0 && k == glitch) start = 1'b0;
         if (glitch > 0 && k == glitch + 3) start = 1'b1;
         if (!busy && done) break;
      end
      chk({name, "_busy_seen"}, int'(seen_busy), 1);
      chk({name, "_finished"}, int'(done && !busy), 1);
      if (glitch > 0) chk({name, "_done_low_while_busy"}, done_bad, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic run_search(input string name, input int tgt, input int settle, input int d,
                             input int glitch, input int efin, input int eboff, input int ebcnt);
      int bad_space;
      target_cnt = NC'(tgt);
      settle_cycles = 8'(settle);
      dly = d;
      kick();
      wait_done(name, glitch);
      chk({name, "_dco"}, int'(dco_ctl_offset), efin);
      chk({name, "_best_offset"}, int'(best_offset), eboff);
      chk({name, "_best_cnt"}, int'(best_cnt), ebcnt);
      chk({name, "_timeout_err"}, int'(timeout_err), 0);
      chk({name, "_loads"}, nloads, NO + 1);
      chk({name, "_first_load"}, load_val[0], 16);
      chk({name, "_final_load"}, load_val[NO], efin);
      bad_space = 0;
      for (int j = 1; j <= NO; j++)
         if (load_cyc[j] - load_cyc[j-1] != settle + d + 3) bad_space++;
      chk({name, "_trial_latency"}, bad_space, 0);
   endtask

   typedef struct {
      int tgt; int slope; int base; int settle; int d;
      int efin; int eboff; int ebcnt;
   } vec_t;

   initial begin
      vec_t vecs [3];
      int fin, boff, bcnt, fs_hi, bad, tgt, st, d;

      vecs[0] = '{400,  20, 100, 4, 8, 15, 15, 400};
      vecs[1] = '{0,    20, 100, 4, 8, 0,  1,  120};
      vecs[2] = '{1000, 20, 100, 1, 2, 31, 31, 720};

      // Reset with start held high: outputs zero, no run afterwards.
      start = 1'b1;
      fill_linear(20, 100);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_outputs", int'({dco_ctl_offset, load_offset, fcal_start, busy, done,
                                 timeout_err, best_offset, best_cnt}), 0);
      bad = 0;
      repeat (8) begin
         @(negedge clk);
         if (busy || load_offset) bad++;
      end
      chk("start_held_through_reset", bad, 0);

      // Fixed vectors.
      for (int v = 0; v < 3; v++) begin
         fill_linear(vecs[v].slope, vecs[v].base);
         run_search($sformatf("vec%0d", v), vecs[v].tgt, vecs[v].settle, vecs[v].d, 0,
                    vecs[v].efin, vecs[v].eboff, vecs[v].ebcnt);
      end

      // Randomized searches against the reference model.
      for (int r = 0; r < 12; r++) begin
         if (r < 6) fill_linear(int'($urandom_range(0, 30)), int'($urandom_range(0, 100)));
         else for (int o = 0; o < 32; o++) tab[o] = int'($urandom_range(0, 1023));
         tgt = int'($urandom_range(0, 1023));
         st  = int'($urandom_range(0, 6));
         d   = int'($urandom_range(1, 10));
         ref_sar(tgt, fin, boff, bcnt);
         run_search($sformatf("rand%0d", r), tgt, st, d, 0, fin, boff, bcnt);
      end

      // Start edge while busy: ignored, identical result.
      fill_linear(20, 100);
      run_search("busy_start", 400, 4, 8, 20, 15, 15, 400);

      // Timeout: no ready ever.
      no_ready = 1'b1;
      settle_cycles = 8'd2;
      kick();
      fs_hi = 0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (fcal_start) fs_hi++;
         if (!busy && done) break;
      end
      chk("timeout_meas_cycles", fs_hi, TO);
      chk("timeout_fcal_start", int'(fcal_start), 0);
      chk("timeout_busy", int'(busy), 0);
      chk("timeout_done", int'(done), 1);
      chk("timeout_err_flag", int'(timeout_err), 1);
      chk("timeout_dco", int'(dco_ctl_offset), 16);
      chk("timeout_best", int'({best_offset, best_cnt}), 0);
      repeat (3) @(negedge clk);
      chk("timeout_loads", nloads, 1);
      no_ready = 1'b0;

      // Zero settle with a tie at offsets 8 and 12.
      for (int o = 0; o < 32; o++) tab[o] = 700;
      tab[16] = 600; tab[8] = 390; tab[12] = 410; tab[10] = 450; tab[9] = 300;
      run_search("tie_zero_settle", 400, 0, 3, 0, 9, 8, 390);
      chk("tie_meas_after_load", fs_rise_cyc - load_cyc[0], 1);

      // Reset during the third trial's measurement, start held high.
      fill_linear(20, 100);
      target_cnt = NC'(400);
      settle_cycles = 8'd4;
      dly = 8;
      kick();
      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (nfs_rise >= 3) break;
      end
      chk("reached_third_meas", int'(nfs_rise >= 3 && fcal_start), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrun_reset_outputs", int'({dco_ctl_offset, load_offset, fcal_start, busy, done,
                                        timeout_err, best_offset, best_cnt}), 0);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || load_offset) bad++;
      end
      chk("midrun_reset_no_restart", bad, 0);
      run_search("after_reset", 400, 4, 8, 0, 15, 15, 400);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
